// File: rtl/div_lut_share_ctrl.sv
// Shares one fixed-latency LUT divider among N requesters and returns an 8.8 quotient with a one-cycle ack.
// Define DIV_LUT_SHARE_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module div_lut_share_ctrl #(
    parameter int unsigned N       = 4,
    parameter int unsigned DIV_LAT = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [8*N-1:0] xin_bus,
    input  logic [8*N-1:0] yin_bus,
    output logic [N-1:0]   ack,
    output logic [15:0]    result,
    output logic           dz,
    output logic           busy,
    output logic [7:0]     div_xin,
    output logic [7:0]     div_yin,
    output logic           div_enbl,
    input  logic [15:0]    div_xyout
);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = $clog2(DIV_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] win_q, win_d;
    logic [7:0]    xin_q, xin_d;
    logic [7:0]    yin_q, yin_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   result_q, result_d;
    logic          dz_q, dz_d;

    logic          sel_found;
    logic [IW-1:0] sel_idx;
    logic [7:0]    sel_x, sel_y;
    logic [7:0]    xin_arr [N];
    logic [7:0]    yin_arr [N];

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign xin_arr[g] = xin_bus[8*g+7 : 8*g];
        assign yin_arr[g] = yin_bus[8*g+7 : 8*g];
    end

`ifdef DIV_LUT_SHARE_FIXED_PRIO_EN
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!sel_found && req[k[IW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = k[IW-1:0];
            end
        end
    end
`else
    logic [IW-1:0] rr_q, rr_d;
    int unsigned   cand;

    // Scan starts at rr_q and wraps; the first set request wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = (32'(rr_q) + k) % N;
            if (!sel_found && req[cand[IW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[IW-1:0];
            end
        end
    end
`endif

    assign sel_x = xin_arr[sel_idx];
    assign sel_y = yin_arr[sel_idx];

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        xin_d    = xin_q;
        yin_d    = yin_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        dz_d     = dz_q;
`ifndef DIV_LUT_SHARE_FIXED_PRIO_EN
        rr_d     = rr_q;
`endif
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    win_d = sel_idx;
                    xin_d = sel_x;
                    yin_d = sel_y;
                    if (sel_y == '0) begin
                        result_d = '1;
                        dz_d     = 1'b1;
                        state_d  = DONE;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = CW'(DIV_LAT);
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    result_d = div_xyout;
                    dz_d     = 1'b0;
                    state_d  = DONE;
                end
            end
            DONE: begin
`ifndef DIV_LUT_SHARE_FIXED_PRIO_EN
                rr_d = (win_q == IW'(N - 1)) ? '0 : win_q + 1'b1;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            win_q    <= '0;
            xin_q    <= '0;
            yin_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            dz_q     <= 1'b0;
`ifndef DIV_LUT_SHARE_FIXED_PRIO_EN
            rr_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            xin_q    <= xin_d;
            yin_q    <= yin_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            dz_q     <= dz_d;
`ifndef DIV_LUT_SHARE_FIXED_PRIO_EN
            rr_q     <= rr_d;
`endif
        end
    end

    always_comb begin
        ack = '0;
        if (state_q == DONE) ack[win_q] = 1'b1;
    end

    assign busy     = (state_q != IDLE);
    assign div_enbl = (state_q == ISSUE);
    assign div_xin  = xin_q;
    assign div_yin  = yin_q;
    assign result   = result_q;
    assign dz       = dz_q;
endmodule

// File: tb/tb_div_lut_share_ctrl.sv
// Self-checking bench for div_lut_share_ctrl: directed cases plus random multi-requester traffic vs. a schedule model.
module tb_div_lut_share_ctrl;
    localparam int N       = 4;
    localparam int DIV_LAT = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req;
    logic [8*N-1:0] xin_bus, yin_bus;
    logic [N-1:0]   ack;
    logic [15:0]    result;
    logic           dz, busy;
    logic [7:0]     div_xin, div_yin;
    logic           div_enbl;
    logic [15:0]    div_xyout;

    always #5 clk = ~clk;

    div_lut_share_ctrl #(.N(N), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .xin_bus(xin_bus), .yin_bus(yin_bus),
        .ack(ack), .result(result), .dz(dz), .busy(busy),
        .div_xin(div_xin), .div_yin(div_yin), .div_enbl(div_enbl), .div_xyout(div_xyout)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] bx [N];
    logic [7:0] by [N];

    // model state
    int          cyc, acc_c, done_c, op_w, rr, enbl_cnt;
    bit          op_dz, exp_dz, rand_mode, hold_all;
    logic [15:0] op_val, exp_res;
    logic [7:0]  op_x, op_y, exp_x, exp_y;
    int          ack_w [$];
    int          ack_c [$];

    // Divider stand-in: the LUT gives 43/256 for a divisor of 6, exact 8.8 division otherwise.
    function automatic logic [15:0] divfn(input logic [7:0] x, input logic [7:0] y);
        if (y == 8'd6) return 16'(int'(x) * 43);
        return 16'((int'(x) * 256) / int'(y));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    endtask

    // Result is valid on div_xyout only for the single cycle it is due; garbage otherwise.
    initial begin : divider_model
        int cd;
        logic [15:0] dval;
        cd = 0;
        dval = '0;
        div_xyout = '0;
        forever begin
            @(negedge clk);
            if (cd != 0) begin
                cd--;
                div_xyout = (cd == 0) ? dval : 16'($urandom);
            end else begin
                div_xyout = 16'($urandom);
            end
            if (div_enbl) begin
                dval = divfn(div_xin, div_yin);
                cd   = DIV_LAT;
            end
        end
    end

    task automatic pack();
        for (int i = 0; i < N; i++) begin
            xin_bus[8*i +: 8] = bx[i];
            yin_bus[8*i +: 8] = by[i];
        end
    endtask

    task automatic model_reset();
        cyc = 0; acc_c = -100; done_c = -100; op_w = 0; rr = 0;
        op_dz = 1'b0; op_val = '0; op_x = '0; op_y = '0;
        exp_res = '0; exp_dz = 1'b0; exp_x = '0; exp_y = '0;
    endtask

    function automatic logic [7:0] rand_y();
        return ($urandom_range(7, 0) == 0) ? 8'd0 : 8'($urandom_range(255, 1));
    endfunction

    // Decides what the controller accepts at the coming edge, from the request lines it will sample.
    task automatic decide();
        int w;
        pack();
        w = -1;
        if (cyc > done_c && req != '0) begin
`ifdef DIV_LUT_SHARE_FIXED_PRIO_EN
            for (int k = 0; k < N; k++) if (w < 0 && req[k]) w = k;
`else
            for (int k = 0; k < N; k++) if (w < 0 && req[(rr + k) % N]) w = (rr + k) % N;
`endif
            acc_c  = cyc;
            op_w   = w;
            op_x   = bx[w];
            op_y   = by[w];
            op_dz  = (op_y == 8'd0);
            op_val = op_dz ? 16'hFFFF : divfn(op_x, op_y);
            done_c = op_dz ? cyc + 1 : cyc + DIV_LAT + 2;
        end
    endtask

    task automatic rand_stim();
        for (int i = 0; i < N; i++) begin
            if (cyc == done_c && i == op_w) begin
                if ($urandom_range(1, 0) == 1) req[i] = 1'b0;
                else begin bx[i] = 8'($urandom); by[i] = rand_y(); end
            end else if (!req[i]) begin
                if ($urandom_range(3, 0) == 0) begin
                    req[i] = 1'b1; bx[i] = 8'($urandom); by[i] = rand_y();
                end
            end else if (cyc > acc_c && cyc < done_c && i == op_w) begin
                case ($urandom_range(7, 0))
                    0: begin bx[i] = 8'($urandom); by[i] = 8'($urandom); end
                    1: req[i] = 1'b0;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic step();
        decide();
        @(negedge clk);
        cyc++;
        if (cyc == acc_c + 1) begin
            exp_x = op_x; exp_y = op_y;
            if (op_dz) begin exp_res = 16'hFFFF; exp_dz = 1'b1; end
        end
        if (cyc == done_c && !op_dz) begin exp_res = op_val; exp_dz = 1'b0; end
        chk("ack", ack, (cyc == done_c) ? (32'd1 << op_w) : 32'd0);
        chk("busy", busy, (cyc > acc_c && cyc <= done_c) ? 1 : 0);
        chk("div_enbl", div_enbl, (!op_dz && cyc == acc_c + 1) ? 1 : 0);
        chk("result", result, exp_res);
        chk("dz", dz, exp_dz);
        chk("div_xin", div_xin, exp_x);
        chk("div_yin", div_yin, exp_y);
        if (div_enbl) enbl_cnt++;
        for (int i = 0; i < N; i++) if (ack[i]) begin ack_w.push_back(i); ack_c.push_back(cyc); end
        if (cyc == done_c) begin
            rr = (op_w + 1) % N;
            if (!hold_all && !rand_mode) req[op_w] = 1'b0;
        end
        if (rand_mode) rand_stim();
    endtask

    initial begin
        req = '0;
        for (int i = 0; i < N; i++) begin bx[i] = '0; by[i] = '0; end
        pack();
        model_reset();
        rand_mode = 1'b0; hold_all = 1'b0; enbl_cnt = 0;

        repeat (3) @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_result", result, 0);
        chk("rst_busy", busy, 0);
        chk("rst_enbl", div_enbl, 0);
        chk("rst_xin", div_xin, 0);
        rst_n = 1'b1;

        req = 4'b0001; bx[0] = 8'd100; by[0] = 8'd6; enbl_cnt = 0;
        repeat (DIV_LAT + 2) step();
        chk("t1_ack", ack, 4'b0001);
        chk("t1_result", result, 16'h10CC);
        chk("t1_dz", dz, 0);
        chk("t1_enbl_pulses", enbl_cnt, 1);
        step();

        req = 4'b0100; bx[2] = 8'd255; by[2] = 8'd1;
        repeat (DIV_LAT + 2) step();
        chk("t2_ack", ack, 4'b0100);
        chk("t2_result", result, 16'hFF00);
        step();

        req = 4'b0010; bx[1] = 8'd9; by[1] = 8'd9;
        repeat (DIV_LAT + 2) step();
        chk("t3_ack", ack, 4'b0010);
        chk("t3_result", result, 16'h0100);
        step();

        req = 4'b0010; bx[1] = 8'd5; by[1] = 8'd0; enbl_cnt = 0;
        step();
        chk("dz_ack", ack, 4'b0010);
        chk("dz_result", result, 16'hFFFF);
        chk("dz_flag", dz, 1);
        step();
        chk("dz_enbl_pulses", enbl_cnt, 0);
        chk("dz_busy_after", busy, 0);

        // Reset in the middle of WAIT, then a fresh request from requester 3.
        req = 4'b0100; bx[2] = 8'd50; by[2] = 8'd5;
        repeat (3) step();
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ack", ack, 0);
        chk("mid_rst_enbl", div_enbl, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_dz", dz, 0);
        req = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        req = 4'b1000; bx[3] = 8'd200; by[3] = 8'd7;
        rst_n = 1'b1;
        repeat (DIV_LAT + 2) step();
        chk("post_rst_ack", ack, 4'b1000);
        chk("post_rst_result", result, 16'h1C92);
        step();

        hold_all = 1'b1;
        for (int i = 0; i < N; i++) begin bx[i] = 8'(20 + 10 * i); by[i] = 8'(3 + i); end
        req = 4'b1111;
        ack_w.delete(); ack_c.delete();
        repeat (25) step();
        chk("all_req_nacks", ack_w.size(), 5);
        for (int j = 0; j < 5; j++) begin
            if (j < ack_w.size()) begin
`ifdef DIV_LUT_SHARE_FIXED_PRIO_EN
                chk("all_req_order", ack_w[j], 0);
`else
                chk("all_req_order", ack_w[j], j % 4);
`endif
                if (j > 0) chk("all_req_spacing", ack_c[j] - ack_c[j-1], 5);
            end
        end
        hold_all = 1'b0;
        req = '0;
        repeat (8) step();

        rand_mode = 1'b1;
        repeat (3000) step();
        rand_mode = 1'b0;
        req = '0;
        repeat (10) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
